// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared types and constants for the seven-segment scanner:
//                scan state enum, active-low hex glyphs (SEG[0]=a..SEG[6]=g),
//                and the all-off patterns for segments and anodes.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational hex digit to active-low seven-segment decoder.
//  Ports       : digit_i [3:0] - hex digit to show
//                seg_o   [6:0] - active-low segments, seg_o[0]=a .. [6]=g
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (digit_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Four-digit time-multiplexed seven-segment driver. Digits are
//                captured into a hold register on LOAD, copied into the
//                active register at every slot start (tear-free), and scanned
//                one anode per slot with a blank interval at slot start.
//  Ports       : CLK, RESET (sync, active-high)
//                LOAD, DIG0..DIG3 [3:0], DP_IN [3:0]   - digit capture
//                AN [3:0], SEG [6:0], DP_N             - active-low pins
//                SLOT_START                            - slot boundary pulse
//  Options     : define LEADING_ZERO_BLANK_EN to suppress leading zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [3:0] DIG0,
  input  logic [3:0] DIG1,
  input  logic [3:0] DIG2,
  input  logic [3:0] DIG3,
  input  logic [3:0] DP_IN,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP_N,
  output logic       SLOT_START
);

  localparam int             PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  BLANK_LAST = PW'(BLANK_CYCLES - 1);

  logic [15:0]   hold_dig_q, active_dig_q;
  logic [3:0]    hold_dp_q,  active_dp_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q;
  state_e        state_q;

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dpn_q;
  logic          slot_start_q;

  logic [3:0]    digit_sel;
  logic [6:0]    seg_dec;
  logic          lz_blank;

  assign pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
  assign digit_sel = active_dig_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .digit_i (digit_sel),
    .seg_o   (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and all higher digits are zero and it
  // carries no decimal point; digit 0 is never suppressed.
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      2'd3: lz_blank = (active_dig_q[15:12] == 4'h0) && !active_dp_q[3];
      2'd2: lz_blank = (active_dig_q[15:8]  == 8'h0) && !active_dp_q[2];
      2'd1: lz_blank = (active_dig_q[15:4]  == 12'h0) && !active_dp_q[1];
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_dig_q   <= '0;
      hold_dp_q    <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      pre_q        <= '0;
      idx_q        <= '0;
      state_q      <= BLANK;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dpn_q        <= 1'b1;
      slot_start_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      if (LOAD) begin
        hold_dig_q <= {DIG3, DIG2, DIG1, DIG0};
        hold_dp_q  <= DP_IN;
      end
      // Transfer samples the pre-edge hold, so a coincident LOAD lands next slot.
      if (pre_q == '0) begin
        active_dig_q <= hold_dig_q;
        active_dp_q  <= hold_dp_q;
      end
      slot_start_q <= (pre_q == '0);

      case (state_q)
        BLANK: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_OFF;
          dpn_q <= 1'b1;
          if (pre_q == BLANK_LAST) state_q <= DRIVE;
        end
        DRIVE: begin
          if (lz_blank) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dpn_q <= 1'b1;
          end else begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_dec;
            dpn_q <= ~active_dp_q[idx_q];
          end
          if (pre_q == PRE_LAST) begin
            state_q <= BLANK;
            idx_q   <= idx_q + 2'd1;
          end
        end
        default: state_q <= BLANK;
      endcase
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP_N       = dpn_q;
  assign SLOT_START = slot_start_q;

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed four-digit seven-segment display driver: consumer of the four 4-bit digit values the BCD counter produces (ones, tens, hundreds, thousands). Captures digits on a load strobe into a hold register, transfers them tear-free at slot boundaries, scans one anode at a time with an anti-ghosting blank interval, and decodes each digit to active-low segments. Sits between the counter and the board's segment/anode pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  reset RESET, synchronous, active-high.
- LOAD  in  1  one-cycle strobe; captures DIG0..DIG3 and DP_IN into the hold register.
- DIG0  in  4  ones digit (displayed on AN[0]).
- DIG1  in  4  tens digit (AN[1]).
- DIG2  in  4  hundreds digit (AN[2]).
- DIG3  in  4  thousands digit (AN[3]).
- DP_IN  in  4  decimal point per digit, 1 = lit.
- AN  out  4  anode enables, active-low, at most one low.
- SEG  out  7  segments, active-low, SEG[0]=a … SEG[6]=g.
- DP_N  out  1  decimal point, active-low.
- SLOT_START  out  1  one-cycle pulse on the first cycle of every slot.

## Operation
- Registers: hold (16+4 bits), active (16+4 bits), prescaler (ceil(log2(SCAN_DIV)) bits), digit index (2 bits), state.
- LOAD=1: hold <= {DIG3..DIG0, DP_IN}. No other handshake; LOAD on consecutive cycles is legal, and the last value wins.
- At each slot start: active <= hold. Index advances 0→1→2→3→0.
- State machine:
  - BLANK: AN=1111, SEG=1111111, DP_N=1. Stay for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: AN[index]=0, SEG=decode(active digit), DP_N=~active DP. Stay until the prescaler reaches SCAN_DIV-1, then go to BLANK with the next index.
- Decode table (hex glyphs, digits 10–15 allowed):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- LOAD coinciding with a slot start: active takes the old hold value; the new value appears from the next slot.

## Timing
- Reset values (cycle after RESET sampled high):
  - AN=1111, SEG=1111111, DP_N=1, SLOT_START=0.
  - hold=0, active=0, index=0, prescaler=0, state=BLANK.
- The first slot after reset release is digit 0. SLOT_START pulses on the first clock after release.
- All outputs are registered, one cycle behind the state and prescaler.
- Slot length is exactly SCAN_DIV cycles. Full frame is 4·SCAN_DIV cycles.
- LOAD-to-display latency is at most one slot plus BLANK_CYCLES plus 1 cycle.
- RESET mid-slot forces the reset values on the next edge; an in-flight hold value is discarded.
- Prescaler wraps to 0 at SCAN_DIV-1. Index wraps from 3 to 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - In DRIVE, digit k (k=3,2,1) keeps AN[k]=1 and SEG=1111111 when it and every higher digit in active are 0 and its DP bit is 0.
  - Digit 0 is always shown.
  - Slot timing is unchanged.
- Undefined: all four digits are always driven; "0007" shows leading zeros.

## Structure
- Package seven_seg_pkg:
  - state enum {BLANK, DRIVE}
  - sixteen segment glyph constants
  - SEG_OFF = 7'b1111111
  - AN_OFF = 4'b1111
- Sub-module seg7_decode: combinational, 4-bit in → 7-bit active-low out. Instantiated once and fed by an index-selected mux.

## Test plan
Bench uses SCAN_DIV=8, BLANK_CYCLES=2.
- Reset: hold RESET 3 cycles → AN=1111, SEG=1111111, DP_N=1. After release, first DRIVE slot has AN=1110.
- Scan order: LOAD digits 1,2,3,4 → AN cycles 1110,1101,1011,0111 with SEG 1111001,0100100,0110000,0011001. Each slot is 6 cycles driven after 2 blank cycles; period is 32 cycles.
- Tear-free load: LOAD 9,9,9,9 at the third cycle of slot 1 → slot 1 still shows the old value. From slot 2 on, SEG=0010000.
- Hex and DP: LOAD DIG0=4'hA, DP_IN=0001 → digit 0 shows SEG=0001000, DP_N=0. Other digits show DP_N=1.
- Leading zeros: LOAD 0,0,0,7 (DIG3..DIG0).
  - With LEADING_ZERO_BLANK_EN: AN stays 1111 in slots 1–3.
  - Without it: AN=0111 in slot 3 and SEG=1000000 in slots 1–3.
- Reset mid-operation: assert RESET during DRIVE of digit 2 → next cycle is all off. Restart at index 0 showing 0 (hold cleared).
